// File: rtl/t06_tile_draw_seq_if.sv
// Request/stream bundle between the frame scanner, the tile sequencer and the
// panel bus driver.
interface t06_tile_draw_seq_if #(
  parameter int COORD_W = 4
);
  logic               req_init;
  logic               req_clear;
  logic               req_tile;
  logic [2:0]         obj_code;
  logic [COORD_W-1:0] x_idx;
  logic [COORD_W-1:0] y_idx;
  logic [15:0]        bg_color;
  logic [7:0]         out_data;
  logic               out_dcx;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               err;

  // Sequencer side
  modport master (
    input  req_init, req_clear, req_tile, obj_code, x_idx, y_idx, bg_color,
    input  out_ready,
    output out_data, out_dcx, out_valid, busy, done, err
  );

  // Requester / bus-driver side
  modport slave (
    output req_init, req_clear, req_tile, obj_code, x_idx, y_idx, bg_color,
    output out_ready,
    input  out_data, out_dcx, out_valid, busy, done, err
  );
endinterface

// File: rtl/t06_tile_draw_seq.sv
// Tile / clear / init command sequencer for an ILI9341-class panel.
// Emits {byte, dcx} on a valid/ready stream; window setup, then RGB565 pixels.
module t06_tile_draw_seq #(
  parameter int          TILE_W    = 20,
  parameter int          TILE_H    = 20,
  parameter int          SCREEN_W  = 240,
  parameter int          SCREEN_H  = 320,
  parameter int          COORD_W   = 4,
  parameter int          DELAY_CYC = 60000,
  parameter logic [15:0] PAL1      = 16'hF0F8,
  parameter logic [15:0] PAL2      = 16'hF800,
  parameter logic [15:0] PAL3      = 16'h00F8,
  parameter logic [15:0] PAL4      = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  t06_tile_draw_seq_if.master     bus
);

  localparam int TILE_PIX = TILE_W * TILE_H;
  localparam int SCRN_PIX = SCREEN_W * SCREEN_H;
  localparam int MAX_PIX  = (TILE_PIX > SCRN_PIX) ? TILE_PIX : SCRN_PIX;
  localparam int PW       = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam int DW       = (DELAY_CYC > 1) ? $clog2(DELAY_CYC + 1) : 1;

  localparam logic [PW-1:0] TILE_LAST = PW'(TILE_PIX - 1);
  localparam logic [PW-1:0] SCRN_LAST = PW'(SCRN_PIX - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_PIX   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    state;
  logic [3:0]    idx;       // byte index within INIT list or window list
  logic [DW-1:0] dly;
  logic [PW-1:0] pix;
  logic          lo_byte;   // 0: colour high byte next, 1: low byte next
  logic          is_clear;
  logic          rej;
  logic [15:0]   color, sc, ec, sp, ep;

  logic [COORD_W-1:0] xi, yi;
  logic [15:0]        t_sc, t_ec, t_sp, t_ep, t_col;
  logic               t_rej;
  logic               xfer;
  logic [7:0]         o_data;
  logic               o_dcx, o_valid;

  assign xi   = bus.x_idx;
  assign yi   = bus.y_idx;
  assign xfer = o_valid & bus.out_ready;

  // Tile window and colour decode from the live request inputs (latched on accept)
  always_comb begin
    t_sc  = 16'(xi) * 16'(TILE_W);
    t_ec  = t_sc + 16'(TILE_W - 1);
    t_sp  = 16'(yi) * 16'(TILE_H);
    t_ep  = t_sp + 16'(TILE_H - 1);
    t_rej = (t_ec >= 16'(SCREEN_W)) || (t_ep >= 16'(SCREEN_H));
    case (bus.obj_code)
      3'd1:    t_col = PAL1;
      3'd2:    t_col = PAL2;
      3'd3:    t_col = PAL3;
      3'd4:    t_col = PAL4;
      default: t_col = bus.bg_color;
    endcase
  end

  // Sequencer state, byte/pixel counters and latched request context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      dly      <= '0;
      pix      <= '0;
      lo_byte  <= 1'b0;
      is_clear <= 1'b0;
      rej      <= 1'b0;
      color    <= '0;
      sc       <= '0;
      ec       <= '0;
      sp       <= '0;
      ep       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx     <= '0;
          dly     <= '0;
          pix     <= '0;
          lo_byte <= 1'b0;
          if (bus.req_init) begin
            state    <= S_INIT;
            is_clear <= 1'b0;
            rej      <= 1'b0;
          end else if (bus.req_clear) begin
            state    <= S_WIN;
            is_clear <= 1'b1;
            rej      <= 1'b0;
            color    <= bus.bg_color;
            sc       <= '0;
            ec       <= 16'(SCREEN_W - 1);
            sp       <= '0;
            ep       <= 16'(SCREEN_H - 1);
          end else if (bus.req_tile) begin
            state    <= t_rej ? S_FIN : S_WIN;
            is_clear <= 1'b0;
            rej      <= t_rej;
            color    <= t_col;
            sc       <= t_sc;
            ec       <= t_ec;
            sp       <= t_sp;
            ep       <= t_ep;
          end
        end
        S_INIT: if (xfer) begin
          if (idx == 4'd4) begin
            state <= S_FIN;
          end else begin
            idx <= idx + 4'd1;
            // SWRESET and SLPOUT need the panel hold-off
            if (idx <= 4'd1) begin
              state <= S_DELAY;
              dly   <= '0;
            end
          end
        end
        S_DELAY: begin
          if (dly == DLY_LAST) state <= S_INIT;
          else                 dly   <= dly + DW'(1);
        end
        S_WIN: if (xfer) begin
          if (idx == 4'd10) begin
            state <= S_PIX;
            idx   <= '0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_PIX: if (xfer) begin
          lo_byte <= ~lo_byte;
          if (lo_byte) begin
            if (pix == (is_clear ? SCRN_LAST : TILE_LAST)) state <= S_FIN;
            else                                           pix   <= pix + PW'(1);
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output byte mux; driven purely from state so it holds while stalled
  always_comb begin
    o_data  = 8'h00;
    o_dcx   = 1'b0;
    o_valid = 1'b0;
    case (state)
      S_INIT: begin
        o_valid = 1'b1;
        case (idx)
          4'd0:    o_data = 8'h01;
          4'd1:    o_data = 8'h11;
          4'd2:    o_data = 8'h3A;
          4'd3:    begin o_data = 8'h55; o_dcx = 1'b1; end
          default: o_data = 8'h29;
        endcase
      end
      S_WIN: begin
        o_valid = 1'b1;
        o_dcx   = 1'b1;
        case (idx)
          4'd0:    begin o_data = 8'h2A; o_dcx = 1'b0; end
          4'd1:    o_data = sc[15:8];
          4'd2:    o_data = sc[7:0];
          4'd3:    o_data = ec[15:8];
          4'd4:    o_data = ec[7:0];
          4'd5:    begin o_data = 8'h2B; o_dcx = 1'b0; end
          4'd6:    o_data = sp[15:8];
          4'd7:    o_data = sp[7:0];
          4'd8:    o_data = ep[15:8];
          4'd9:    o_data = ep[7:0];
          default: begin o_data = 8'h2C; o_dcx = 1'b0; end
        endcase
      end
      S_PIX: begin
        o_valid = 1'b1;
        o_dcx   = 1'b1;
        o_data  = lo_byte ? color[7:0] : color[15:8];
      end
      default: ;
    endcase
  end

  assign bus.out_data  = o_data;
  assign bus.out_dcx   = o_dcx;
  assign bus.out_valid = o_valid;
  assign bus.busy      = (state != S_IDLE) && (state != S_FIN);
  assign bus.done      = (state == S_FIN);
  assign bus.err       = (state == S_FIN) && rej;

endmodule

// File: tb/tb_t06_tile_draw_seq.sv
// Randomised bench for t06_tile_draw_seq against a byte-list reference model.
module tb_t06_tile_draw_seq;
  localparam int TW = 20, TH = 20, SW = 240, SH = 320, CW = 4, DLY = 10;
  localparam int BUDGET = 6000;

  logic clk = 1'b0;
  logic rst;

  t06_tile_draw_seq_if #(.COORD_W(CW)) bus();

  t06_tile_draw_seq #(
    .TILE_W(TW), .TILE_H(TH), .SCREEN_W(SW), .SCREEN_H(SH),
    .COORD_W(CW), .DELAY_CYC(DLY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: expected {dcx,byte} list ----------------
  logic [8:0] exp_q[$];
  int         exp_total;

  function automatic logic [15:0] pal(input int code, input logic [15:0] bg);
    case (code)
      1: return 16'hF0F8;
      2: return 16'hF800;
      3: return 16'h00F8;
      4: return 16'h0000;
      default: return bg;
    endcase
  endfunction

  task automatic push(input logic dcx, input logic [7:0] b);
    exp_q.push_back({dcx, b});
  endtask

  task automatic push16(input logic [15:0] v);
    push(1'b1, v[15:8]);
    push(1'b1, v[7:0]);
  endtask

  task automatic model_init();
    exp_q.delete();
    push(0, 8'h01); push(0, 8'h11); push(0, 8'h3A); push(1, 8'h55); push(0, 8'h29);
    exp_total = exp_q.size();
  endtask

  // window + npix pixels of colour col
  task automatic model_fill(input int c0, input int c1, input int p0, input int p1,
                            input logic [15:0] col, input int npix);
    exp_q.delete();
    push(0, 8'h2A); push16(16'(c0)); push16(16'(c1));
    push(0, 8'h2B); push16(16'(p0)); push16(16'(p1));
    push(0, 8'h2C);
    for (int i = 0; i < npix; i++) push16(col);
    exp_total = exp_q.size();
  endtask

  task automatic model_tile(input int x, input int y, input int obj, input logic [15:0] bg);
    int c0, p0;
    c0 = x * TW;
    p0 = y * TH;
    if (c0 + TW - 1 >= SW || p0 + TH - 1 >= SH) begin
      exp_q.delete();
      exp_total = 0;
    end else begin
      model_fill(c0, c0 + TW - 1, p0, p0 + TH - 1, pal(obj, bg), TW * TH);
    end
  endtask

  // ---------------- stream driver / monitor ----------------
  int   r_nbytes, r_tail, r_stall_bad, r_busy_bad;
  logic r_done, r_err;
  int   gaps[$];

  // kind: 0 init, 1 clear, 2 tile, 3 clear+tile together
  task automatic run(input int kind, input bit rnd, input int stop_at, input bit poke);
    int         cyc, gap, since;
    bit         prev_stall;
    logic [8:0] prev, cur;
    cyc = 0; gap = 0; since = 0; prev_stall = 0; prev = '0;
    r_nbytes = 0; r_tail = -1; r_stall_bad = 0; r_busy_bad = 0;
    r_done = 0; r_err = 0;
    gaps.delete();
    @(posedge clk); #1;
    bus.req_init  = (kind == 0);
    bus.req_clear = (kind == 1 || kind == 3);
    bus.req_tile  = (kind == 2 || kind == 3);
    @(posedge clk); #1;
    bus.req_init = 0; bus.req_clear = 0; bus.req_tile = 0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.req_init  = poke && (cyc == 5);
      #1;
      if (bus.done) begin
        r_done = 1; r_err = bus.err; r_tail = since;
        if (bus.busy) r_busy_bad++;
        break;
      end
      if (!bus.busy) r_busy_bad++;
      cur = {bus.out_dcx, bus.out_data};
      if (prev_stall && (!bus.out_valid || cur !== prev)) r_stall_bad++;
      since++;
      if (bus.out_valid && bus.out_ready) begin
        gaps.push_back(gap);
        gap = 0; since = 0; prev_stall = 0;
        if (exp_q.size() == 0) chk("byte_count", r_nbytes + 1, exp_total);
        else chk($sformatf("byte%0d", r_nbytes), cur, exp_q.pop_front());
        r_nbytes++;
        if (stop_at > 0 && r_nbytes == stop_at) break;
      end else if (bus.out_valid) begin
        prev_stall = 1; prev = cur;
      end else begin
        gap++; prev_stall = 0;
      end
    end
    bus.req_init = 0;
    if (cyc >= BUDGET) chk("timeout", cyc, 0);
  endtask

  // checks common to a completed, accepted request
  task automatic check_ok(input string tag);
    chk({tag, "_nbytes"}, r_nbytes, exp_total);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_done"}, r_done, 1);
    chk({tag, "_err"}, r_err, 0);
    chk({tag, "_busy"}, r_busy_bad, 0);
    chk({tag, "_stall"}, r_stall_bad, 0);
    @(negedge clk); #1;
    chk({tag, "_done_once"}, bus.done, 0);
    chk({tag, "_idle"}, {bus.busy, bus.out_valid}, 0);
  endtask

  initial begin
    int x, y, ob;
    logic [15:0] bg;
    rst = 1;
    bus.req_init = 0; bus.req_clear = 0; bus.req_tile = 0;
    bus.obj_code = 0; bus.x_idx = 0; bus.y_idx = 0; bus.bg_color = 0;
    bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {bus.out_valid, bus.busy, bus.done, bus.err, bus.out_dcx, bus.out_data}, 0);
    rst = 0;

    // INIT with short delays and ready held high
    model_init();
    run(0, 0, 0, 0);
    chk("init_tail", r_tail, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("init_gap%0d", i), gaps.size() > i ? gaps[i] : -1, (i == 1 || i == 2) ? DLY : 0);
    check_ok("init");

    // Directed tile, ready high, stray req_init while busy
    bus.x_idx = 2; bus.y_idx = 3; bus.obj_code = 2; bus.bg_color = 16'h1234;
    model_tile(2, 3, 2, 16'h1234);
    run(2, 0, 0, 1);
    chk("tile_tail", r_tail, 0);
    check_ok("tile");

    // Same tile, random back-pressure
    model_tile(2, 3, 2, 16'h1234);
    run(2, 1, 0, 0);
    check_ok("tile_rnd");

    // Rejected tile: SC = 240
    bus.x_idx = 12; bus.y_idx = 0;
    model_tile(12, 0, 2, 16'h1234);
    run(2, 0, 0, 0);
    chk("rej_nbytes", r_nbytes, 0);
    chk("rej_done", r_done, 1);
    chk("rej_err", r_err, 1);
    @(negedge clk); #1;
    chk("rej_once", {bus.done, bus.err}, 0);

    // Out-of-palette code uses background colour
    bus.x_idx = 0; bus.y_idx = 0; bus.obj_code = 7; bus.bg_color = 16'hE580;
    model_tile(0, 0, 7, 16'hE580);
    run(2, 1, 0, 0);
    check_ok("bgcol");

    // Random tiles, random stalls (corner tiles included in range)
    for (int k = 0; k < 3; k++) begin
      x  = $urandom_range(0, SW / TW - 1);
      y  = $urandom_range(0, SH / TH - 1);
      ob = $urandom_range(0, 7);
      bg = 16'($urandom);
      bus.x_idx = CW'(x); bus.y_idx = CW'(y); bus.obj_code = 3'(ob); bus.bg_color = bg;
      model_tile(x, y, ob, bg);
      run(2, 1, 0, 0);
      check_ok($sformatf("rtile%0d", k));
    end

    // clear+tile together: CLEAR wins; abort with reset mid-PIXEL
    bg = 16'($urandom);
    bus.bg_color = bg; bus.x_idx = 1; bus.y_idx = 1; bus.obj_code = 1;
    model_fill(0, SW - 1, 0, SH - 1, bg, 30);
    run(3, 0, 71, 0);
    chk("clr_nbytes", r_nbytes, 71);
    chk("clr_left", exp_q.size(), 0);
    chk("clr_valid_pre", bus.out_valid, 1);
    rst = 1;
    #1;
    chk("abort_outs", {bus.out_valid, bus.busy, bus.done}, 0);
    bus.out_ready = 0;
    @(posedge clk); #1;
    rst = 0;

    // Block is idle and accepts a fresh tile after reset
    bus.x_idx = 11; bus.y_idx = 15; bus.obj_code = 3;
    model_tile(11, 15, 3, bg);
    run(2, 1, 0, 0);
    check_ok("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/t06_tile_draw_seq.md
Name: t06_tile_draw_seq

Overview:
- Parametrised successor of the team's fixed-geometry LCD command sequencer. Emits 8-bit command/data bytes with a D/C flag for an ILI9341-class panel.
- Supports three request types:
  - INIT: panel power-up sequence with hold-off delays.
  - CLEAR: fill the whole screen with the background colour.
  - TILE: fill one grid cell with a palette colour.
- Tile size, screen size, grid-coordinate width and palette are parameters.
- Output is a valid/ready byte stream, so it sits between the game-logic frame scanner and the SPI/8080 bus driver, which may stall it.

Parameters:
TILE_W, 20, tile width in pixels
TILE_H, 20, tile height in pixels
SCREEN_W, 240, panel columns
SCREEN_H, 320, panel rows
COORD_W, 4, width of grid coordinates x_idx/y_idx
DELAY_CYC, 60000, idle cycles after SWRESET and after SLPOUT
PAL1, 16'hF0F8, colour for obj_code 1
PAL2, 16'hF800, colour for obj_code 2
PAL3, 16'h00F8, colour for obj_code 3
PAL4, 16'h0000, colour for obj_code 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_init  in  1  start INIT sequence (sampled in IDLE only)
req_clear  in  1  start CLEAR (sampled in IDLE only)
req_tile  in  1  start TILE fill (sampled in IDLE only)
obj_code  in  3  tile object code, captured at acceptance
x_idx  in  COORD_W  tile column index, captured at acceptance
y_idx  in  COORD_W  tile row index, captured at acceptance
bg_color  in  16  RGB565 background, captured at acceptance
out_data  out  8  byte to panel
out_dcx  out  1  0 = command byte, 1 = data byte
out_valid  out  1  out_data/out_dcx valid
out_ready  in  1  bus driver accepts byte this cycle
busy  out  1  high from acceptance until done
done  out  1  one-cycle pulse when the last byte is accepted or the request is rejected
err  out  1  one-cycle pulse with done on rejected TILE

Behaviour:
- Reset (async, rst=1): state IDLE; out_data=0, out_dcx=0, out_valid=0, busy=0, done=0, err=0; all counters 0.
- Acceptance, IDLE only:
  - Priority when several requests are high: init > clear > tile.
  - Inputs are latched on the accepting edge; busy rises on the next cycle.
  - Requests while busy are ignored, not queued.
- Handshake:
  - A byte transfers on a cycle where out_valid & out_ready.
  - While out_valid & !out_ready, out_data/out_dcx are held stable.
  - The next byte may be presented on the cycle after a transfer, so one byte per cycle is possible with ready held high.
- States: IDLE, INIT_BYTE, DELAY, WIN_BYTE, PIXEL, FINISH.
- INIT byte list, in order ({byte, dcx}):
  - 0x01/0 (SWRESET), then DELAY
  - 0x11/0 (SLPOUT), then DELAY
  - 0x3A/0, 0x55/1 (COLMOD 16-bit)
  - 0x29/0 (DISPON)
  - DELAY: out_valid=0 for exactly DELAY_CYC cycles after the preceding byte transfers.
- WIN_BYTE, 11 bytes:
  - 0x2A/0, then SC[15:8], SC[7:0], EC[15:8], EC[7:0] all dcx=1
  - 0x2B/0, then SP[15:8], SP[7:0], EP[15:8], EP[7:0] all dcx=1
  - 0x2C/0
  - TILE: SC=x_idx*TILE_W, EC=SC+TILE_W-1, SP=y_idx*TILE_H, EP=SP+TILE_H-1.
  - CLEAR: SC=0, EC=SCREEN_W-1, SP=0, EP=SCREEN_H-1.
  - End coordinates are inclusive.
  - Arithmetic is done in 16 bits, zero-extended.
- PIXEL:
  - Each pixel is sent as colour[15:8] then colour[7:0], both dcx=1.
  - Pixel count is TILE_W*TILE_H for TILE and SCREEN_W*SCREEN_H for CLEAR.
  - The counter is sized by $clog2 of the larger count.
  - The final low byte transfer moves to FINISH.
- Colour selection: obj_code 1..4 map to PAL1..PAL4; any other value uses the latched bg_color. CLEAR always uses bg_color.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, return to IDLE. A new request can be accepted the following cycle.
- Rejection: a TILE whose EC >= SCREEN_W or EP >= SCREEN_H emits no bytes. The block spends one cycle in FINISH with done=1 and err=1.
- Mid-operation reset: all activity aborts immediately and out_valid drops asynchronously. No partial sequence resumes.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- rst pulse mid-PIXEL with out_valid=1 -> out_valid, busy, done drop at once; after release the block is idle and accepts a new req_tile.
- DELAY_CYC=10, req_init, out_ready=1 -> bytes 01/0, 10 cycles gap, 11/0, 10 cycles gap, 3A/0, 55/1, 29/0; done pulse on the cycle after 29 transfers.
- req_tile x_idx=2, y_idx=3, obj_code=2, out_ready=1 -> 2A/0, 00,28,00,3B /1, 2B/0, 00,3C,00,4F /1, 2C/0, then 400 × (F8/1,00/1); busy=1 throughout; single done.
- Same tile with out_ready toggling randomly (~50%) -> identical byte sequence, byte held stable while stalled, no drops or duplicates.
- req_tile x_idx=12 (SC=240 ≥ SCREEN_W) -> zero bytes, done=err=1 for one cycle; req_clear+req_tile together -> CLEAR runs, window 0..239 × 0..319 with bg_color.
- obj_code=7, bg_color=E580 -> pixels E5/1, 80/1.
